// File: rtl/lc3_decode.sv
// lc3_decode: LC-3 decode stage sitting behind the fetch unit.
// After a decode_start pulse it waits MEM_LAT cycles for instruction memory,
// latches the word into ir, then registers the decoded fields and pulses
// decode_done for one cycle.
// Optional feature macro: LC3_DECODE_TRAP_EN adds the trapvect8 output and
// makes opcode 1111 (TRAP) legal.
module lc3_decode #(
   parameter int MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        decode_start,
   input  logic [15:0] mem_dout,
   output logic [15:0] ir,
   output logic [3:0]  opCode_out,
   output logic [2:0]  dr_sr,
   output logic [2:0]  sr1,
   output logic [2:0]  sr2,
   output logic        imm_mode,
   output logic [15:0] imm5_sext,
   output logic [15:0] offset6_sext,
   output logic [8:0]  offset9,
   output logic [10:0] offset11,
   output logic        jsr_mode,
   output logic [2:0]  br_nzp,
   output logic        illegal,
   output logic        decode_busy,
`ifdef LC3_DECODE_TRAP_EN
   output logic [7:0]  trapvect8,
`endif
   output logic        decode_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      LATCH = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Counter value on the last WAIT cycle: memory data is valid on the
   // edge that leaves WAIT, MEM_LAT edges after decode_start was sampled.
   localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic        at_last;

   function automatic logic [15:0] sext5(input logic [4:0] f);
      return {{11{f[4]}}, f};
   endfunction

   function automatic logic [15:0] sext6(input logic [5:0] f);
      return {{10{f[5]}}, f};
   endfunction

   // RTI (1000) is unsupported and 1101 is reserved; TRAP depends on build.
   function automatic logic is_illegal(input logic [3:0] op);
      logic bad;
      bad = (op == 4'b1101) || (op == 4'b1000);
`ifndef LC3_DECODE_TRAP_EN
      bad = bad || (op == 4'b1111);
`endif
      return bad;
   endfunction

   assign at_last     = (cnt == LAST_CNT);
   assign decode_busy = (state != IDLE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; starts outside IDLE are dropped, nothing is queued.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (decode_start) state_nxt = WAIT;
         WAIT:    if (at_last)      state_nxt = LATCH;
         LATCH:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Wait counter: cleared on accept, counts memory-latency cycles in WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 4'd0;
      end else if (state == IDLE) begin
         if (decode_start) cnt <= 4'd0;
      end else if (state == WAIT) begin
         cnt <= cnt + 4'd1;
      end
   end

   // Instruction register captures memory data on the edge entering LATCH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir <= 16'd0;
      end else if (state == WAIT && at_last) begin
         ir <= mem_dout;
      end
   end

   // Field outputs are registered from ir on the edge entering DONE and
   // otherwise hold their last decoded values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opCode_out   <= 4'd0;
         dr_sr        <= 3'd0;
         sr1          <= 3'd0;
         sr2          <= 3'd0;
         imm_mode     <= 1'b0;
         imm5_sext    <= 16'd0;
         offset6_sext <= 16'd0;
         offset9      <= 9'd0;
         offset11     <= 11'd0;
         jsr_mode     <= 1'b0;
         br_nzp       <= 3'd0;
         illegal      <= 1'b0;
`ifdef LC3_DECODE_TRAP_EN
         trapvect8    <= 8'd0;
`endif
      end else if (state == LATCH) begin
         opCode_out   <= ir[15:12];
         dr_sr        <= ir[11:9];
         sr1          <= ir[8:6];
         sr2          <= ir[2:0];
         imm_mode     <= ir[5];
         imm5_sext    <= sext5(ir[4:0]);
         offset6_sext <= sext6(ir[5:0]);
         offset9      <= ir[8:0];
         offset11     <= ir[10:0];
         jsr_mode     <= ir[11];
         br_nzp       <= ir[11:9];
         illegal      <= is_illegal(ir[15:12]);
`ifdef LC3_DECODE_TRAP_EN
         trapvect8    <= ir[7:0];
`endif
      end
   end

   // Done strobe is high for the single cycle spent in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         decode_done <= 1'b0;
      end else begin
         decode_done <= (state == LATCH);
      end
   end

endmodule

// File: tb/tb_lc3_decode.sv
// tb_lc3_decode: randomized and directed bench for lc3_decode with a
// field-level reference model computed from the instruction word.
module tb_lc3_decode;

   localparam int MEM_LAT = 2;
`ifdef LC3_DECODE_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        decode_start;
   logic [15:0] mem_dout;
   logic [15:0] ir;
   logic [3:0]  opCode_out;
   logic [2:0]  dr_sr;
   logic [2:0]  sr1;
   logic [2:0]  sr2;
   logic        imm_mode;
   logic [15:0] imm5_sext;
   logic [15:0] offset6_sext;
   logic [8:0]  offset9;
   logic [10:0] offset11;
   logic        jsr_mode;
   logic [2:0]  br_nzp;
   logic        illegal;
   logic        decode_busy;
   logic        decode_done;
`ifdef LC3_DECODE_TRAP_EN
   logic [7:0]  trapvect8;
`endif

   lc3_decode #(.MEM_LAT(MEM_LAT)) dut (
      .clk          (clk),
      .rst          (rst),
      .decode_start (decode_start),
      .mem_dout     (mem_dout),
      .ir           (ir),
      .opCode_out   (opCode_out),
      .dr_sr        (dr_sr),
      .sr1          (sr1),
      .sr2          (sr2),
      .imm_mode     (imm_mode),
      .imm5_sext    (imm5_sext),
      .offset6_sext (offset6_sext),
      .offset9      (offset9),
      .offset11     (offset11),
      .jsr_mode     (jsr_mode),
      .br_nzp       (br_nzp),
      .illegal      (illegal),
      .decode_busy  (decode_busy),
`ifdef LC3_DECODE_TRAP_EN
      .trapvect8    (trapvect8),
`endif
      .decode_done  (decode_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Expected decoded fields (reference model state).
   int x_op, x_dr, x_sr1, x_sr2, x_imm, x_imm5, x_off6, x_off9, x_off11;
   int x_jsr, x_nzp, x_ill, x_trap;
   logic [15:0] cur_ir;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference decode from instruction-word arithmetic.
   task automatic model(input logic [15:0] w);
      int wi, v;
      wi      = int'(w);
      x_op    = wi / 4096;
      x_dr    = (wi / 512) % 8;
      x_sr1   = (wi / 64) % 8;
      x_sr2   = wi % 8;
      x_imm   = (wi / 32) % 2;
      v = wi % 32;
      if (v >= 16) v -= 32;
      x_imm5  = v & 32'hFFFF;
      v = wi % 64;
      if (v >= 32) v -= 64;
      x_off6  = v & 32'hFFFF;
      x_off9  = wi % 512;
      x_off11 = wi % 2048;
      x_jsr   = (wi / 2048) % 2;
      x_nzp   = x_dr;
      x_trap  = wi % 256;
      x_ill   = (x_op == 13 || x_op == 8 || (x_op == 15 && !TRAP_EN)) ? 1 : 0;
   endtask

   task automatic check_fields(input string pfx);
      chk({pfx, ".opcode"},   32'(opCode_out),   32'(x_op));
      chk({pfx, ".dr_sr"},    32'(dr_sr),        32'(x_dr));
      chk({pfx, ".sr1"},      32'(sr1),          32'(x_sr1));
      chk({pfx, ".sr2"},      32'(sr2),          32'(x_sr2));
      chk({pfx, ".imm_mode"}, 32'(imm_mode),     32'(x_imm));
      chk({pfx, ".imm5"},     32'(imm5_sext),    32'(x_imm5));
      chk({pfx, ".off6"},     32'(offset6_sext), 32'(x_off6));
      chk({pfx, ".off9"},     32'(offset9),      32'(x_off9));
      chk({pfx, ".off11"},    32'(offset11),     32'(x_off11));
      chk({pfx, ".jsr"},      32'(jsr_mode),     32'(x_jsr));
      chk({pfx, ".nzp"},      32'(br_nzp),       32'(x_nzp));
      chk({pfx, ".illegal"},  32'(illegal),      32'(x_ill));
`ifdef LC3_DECODE_TRAP_EN
      chk({pfx, ".trapvect"}, 32'(trapvect8),    32'(x_trap));
`endif
   endtask

   // One decode. Memory data is valid only just before edge E0+MEM_LAT.
   // extra_k > 0 raises decode_start again before edge E0+extra_k.
   task automatic do_decode(input logic [15:0] w, input int extra_k);
      logic [15:0] old_ir;
      old_ir = cur_ir;
      @(negedge clk);
      decode_start = 1'b1;
      mem_dout     = ~w;
      @(posedge clk);
      #1 decode_start = 1'b0;
      for (int k = 1; k <= MEM_LAT + 2; k++) begin
         mem_dout     = (k == MEM_LAT) ? w : ~w;
         decode_start = (k == extra_k);
         @(posedge clk);
         #1 decode_start = 1'b0;
         @(negedge clk);
         chk("done", 32'(decode_done), 32'(k == MEM_LAT + 1));
         chk("busy", 32'(decode_busy), 32'(k <= MEM_LAT + 1));
         chk("ir",   32'(ir),          32'((k >= MEM_LAT) ? w : old_ir));
         if (k == MEM_LAT + 1) model(w);
         check_fields((k <= MEM_LAT) ? "hold" : "dec");
      end
      cur_ir = w;
      // One idle cycle: a start at the DONE->IDLE edge must not have begun a decode.
      mem_dout = ~w;
      @(negedge clk);
      chk("idle_busy", 32'(decode_busy), 32'd0);
      chk("idle_done", 32'(decode_done), 32'd0);
   endtask

   initial begin
      rst          = 1'b1;
      decode_start = 1'b0;
      mem_dout     = 16'h0;
      cur_ir       = 16'h0;
      model(16'h0);
      repeat (2) @(negedge clk);
      chk("rst.ir",   32'(ir),          32'd0);
      chk("rst.busy", 32'(decode_busy), 32'd0);
      chk("rst.done", 32'(decode_done), 32'd0);
      check_fields("rst");
      rst = 1'b0;

      // Directed cases from the plan.
      do_decode(16'h12BD, 0);            // ADD immediate
      do_decode(16'h6705, 0);            // LDR
      do_decode(16'h0DFE, 1);            // BR, extra start during WAIT
      do_decode(16'hD000, 0);            // reserved opcode
      do_decode(16'hF025, 0);            // TRAP, legality depends on build
      do_decode(16'h8000, 0);            // RTI
      do_decode(16'h4A3C, MEM_LAT + 2);  // start at DONE->IDLE edge is dropped

      // Asynchronous reset in the middle of a decode.
      @(negedge clk);
      decode_start = 1'b1;
      mem_dout     = 16'h5555;
      @(posedge clk);
      #1 decode_start = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      model(16'h0);
      cur_ir = 16'h0;
      chk("arst.ir",   32'(ir),          32'd0);
      chk("arst.busy", 32'(decode_busy), 32'd0);
      chk("arst.done", 32'(decode_done), 32'd0);
      check_fields("arst");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < MEM_LAT + 3; i++) begin
         @(negedge clk);
         chk("arst.no_done", 32'(decode_done), 32'd0);
         chk("arst.idle",    32'(decode_busy), 32'd0);
      end
      do_decode(16'h3E7F, 0);

      // Randomized back-to-back decodes.
      for (int i = 0; i < 60; i++) begin
         logic [15:0] w;
         int extra;
         w = 16'($urandom);
         extra = (($urandom % 4) == 0) ? int'($urandom_range(1, MEM_LAT + 2)) : 0;
         do_decode(w, extra);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
